// File: rtl/fetch_unit.sv
// Instruction-fetch controller: owns the PC, fetches one word per cycle from a
// combinational memory into a small circular prefetch buffer drained by decode.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_inst,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              dec_ready,
    output logic              dec_valid,
    output logic [31:0]       dec_inst,
    output logic [ADDR_W-1:0] dec_pc
);

    localparam int unsigned PW = (DEPTH == 4) ? 2 : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;

    logic [ADDR_W-1:0] bufPc_q   [DEPTH];
    logic [31:0]       bufInst_q [DEPTH];

    logic deq;
    logic enq;
    logic unusedAddrBits;

    assign unusedAddrBits = ^branch_addr[1:0];

    assign dec_valid = (count_q != '0);
    assign deq       = dec_valid && dec_ready;
    // A full buffer may still accept a word when decode frees the head slot.
    assign enq       = !branch_taken && ((count_q != FULL) || deq);

    assign imem_addr = pc_q;
    assign dec_inst  = dec_valid ? bufInst_q[rdPtr_q] : '0;
    assign dec_pc    = dec_valid ? bufPc_q[rdPtr_q]   : '0;

    always_comb begin
        pc_d    = pc_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (branch_taken) begin
            pc_d    = {branch_addr[ADDR_W-1:2], 2'b00};
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                pc_d    = pc_q + ADDR_W'(4);
                wrPtr_d = wrPtr_q + PW'(1);
            end
            if (deq) begin
                rdPtr_d = rdPtr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Buffer contents are qualified by count, so they need no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            bufPc_q[wrPtr_q]   <= pc_q;
            bufInst_q[wrPtr_q] <= imem_inst;
        end
    end

endmodule
